// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/bank fetch from InstructionMemory into a prefetch FIFO for decode; define IFU_MISALIGN_TRAP_EN to trap misaligned redirects.
module instr_fetch_unit #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH = 2,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0,
  parameter logic BOOT_SEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] Address,
  output logic              sel,
  input  logic [DATA_W-1:0] Data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              redirect_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_sel,
  output logic              misalign_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic              sel_q [DEPTH];
  logic [PW-1:0] rp, wp;
  logic [CW-1:0] cnt;
  logic halted, pop, fetch, push;
`ifdef IFU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      halted <= 1'b0;
      misalign_err <= 1'b0;
    end else if (redirect && redirect_pc[1:0] != 2'b00) begin
      halted <= 1'b1;
      misalign_err <= 1'b1;
    end
`else
  assign halted = 1'b0;
  assign misalign_err = 1'b0;
`endif
  assign out_valid = cnt != '0;
  assign out_instr = instr_q[rp];
  assign out_pc = pc_q[rp];
  assign out_sel = sel_q[rp];
  assign pop = out_valid && out_ready;
  assign fetch = (cnt < CW'(DEPTH) || pop) && !halted;
  assign push = fetch && !redirect;
  // redirect wins over push; a coincident pop is consumed and then flushed with the rest
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      Address <= BOOT_ADDR;
      sel <= BOOT_SEL;
      rp <= '0;
      wp <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i] <= '0;
        sel_q[i] <= 1'b0;
      end
    end else if (redirect) begin
      Address <= redirect_pc & ~ADDR_W'(3);
      sel <= redirect_sel;
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        instr_q[wp] <= Data;
        pc_q[wp] <= Address;
        sel_q[wp] <= sel;
        wp <= wp + PW'(1);
        Address <= Address + ADDR_W'(4);
      end
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Reader side of the 512-byte, dual-bank `InstructionMemory` ROM.
- Holds the program counter and bank select, and drives `Address`/`sel` every cycle.
- Captures the combinational `Data` together with the PC that produced it into a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake, with a branch/jump redirect that flushes the FIFO.
- Sits between `InstructionMemory` and the decode stage of the MIPS core.

## Interface
- `ADDR_W`, default 9: byte-address width; matches `Address`.
- `DATA_W`, default 32: instruction width.
- `DEPTH`, default 2: prefetch FIFO entries; must be a power of two, ≥2.
- `BOOT_ADDR`, default 9'h000: PC after reset; must be word-aligned.
- `BOOT_SEL`, default 1'b0: bank select after reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Address`  out  ADDR_W  ROM byte address; equals the PC register.
- `sel`  out  1  ROM bank select; equals the sel register.
- `Data`  in  DATA_W  ROM read data; combinational from `Address`/`sel`.
- `redirect`  in  1  flush and load a new PC/bank this cycle.
- `redirect_pc`  in  ADDR_W  target byte address.
- `redirect_sel`  in  1  target bank.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  decode accepts the head.
- `out_instr`  out  DATA_W  head instruction.
- `out_pc`  out  ADDR_W  byte address of the head instruction.
- `out_sel`  out  1  bank of the head instruction.
- `misalign_err`  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- State: PC register, sel register, and a FIFO of {instr, pc, sel} with read/write pointers and an occupancy count (0..DEPTH).
- **pop** = `out_valid` && `out_ready`.
- **fetch** = (count < DEPTH || pop) && !halted.
- **push** = fetch && !`redirect`. On push:
  - write {`Data`, PC, sel} at the write pointer;
  - PC ← PC + 4, truncated to ADDR_W, so 0x1FC wraps to 0x000;
  - sel is unchanged.
- When `redirect` = 1, at the next edge:
  - all FIFO entries are discarded and count ← 0; a pop asserted in the same cycle still counts as consumed by decode;
  - PC ← `redirect_pc` with bits [1:0] forced to 0;
  - sel ← `redirect_sel`;
  - no push occurs that cycle.
- Full FIFO with a pop: push and pop in the same cycle; count is unchanged.
- Full FIFO without a pop: no push; PC holds; `Address` is stable.
- Empty FIFO: `out_valid` = 0; `out_instr`, `out_pc` and `out_sel` are driven with the stale head-slot contents. Decode must ignore them.
- Reset values:
  - PC = BOOT_ADDR; sel = BOOT_SEL;
  - count = 0; pointers = 0;
  - `out_valid` = 0; `misalign_err` = 0; FIFO storage = 0.
- Reset asserted mid-stream: all state is cleared immediately and asynchronously; in-flight entries are lost.

## Timing
- `Address`/`sel` change only after a clock edge and are registered outputs with no combinational path from inputs.
- Fetch-to-valid latency: 1 cycle. The instruction at PC sampled at edge *t* is visible as the head after edge *t*.
- Redirect-to-first-valid latency: 2 edges.
  - Edge 1 loads the PC.
  - Edge 2 pushes the target instruction.
  - `out_valid` is high after edge 2.
- Throughput: 1 instruction per cycle while `out_ready` is held high.
- `out_*` are driven from FIFO registers. `out_valid` depends only on count, never combinationally on `out_ready`.
- `redirect` has priority over push. When redirect and pop occur together, the pop is accepted and then the FIFO is flushed.

## Configuration
`IFU_MISALIGN_TRAP_EN`:
- **Defined:** a redirect with `redirect_pc[1:0]` ≠ 0 sets `misalign_err` ← 1 and halted ← 1 at that edge.
  - The FIFO is still flushed, and the PC still loads the masked address.
  - While halted, fetch = 0 and `out_valid` stays 0 until `rst_n` is asserted.
  - Later redirects do not clear the halt.
- **Undefined:** low bits are silently masked, `misalign_err` is tied to 0, and there is no halted state.

## Test plan
- **Reset and streaming:** reset, `out_ready` = 1, ROM with bank 0 words n at 4n.
  - First edge after reset release: `Address` = 000 until then, `out_valid` = 0.
  - Then `out_pc` = 000, 004, 008, … on consecutive cycles.
  - `out_instr` matches ROM; no gaps.
- **Backpressure:** `out_ready` = 0 from reset.
  - After 2 edges: count = 2; `Address` holds at 008; `out_pc` stays 000.
  - Raise `out_ready` for 1 cycle: `out_pc` → 004; `Address` → 00C.
- **Redirect across banks:** while streaming at 010, pulse `redirect` with pc = 9'h040, sel = 1.
  - Next edge: `out_valid` = 0, `Address` = 040, `sel` = 1.
  - Following edge: `out_pc` = 040, `out_sel` = 1, `out_instr` = rom1[040].
- **Wrap-around:** redirect to 1F8 and stream.
  - `out_pc` sequence is 1F8, 1FC, 000, 004; `sel` is unchanged.
- **Reset mid-stream:** assert `rst_n` = 0 asynchronously between edges with FIFO full.
  - `out_valid` = 0 and `Address` = BOOT_ADDR immediately, without waiting for a clock edge.
- **Misaligned redirect** (macro defined): redirect to 9'h042.
  - `misalign_err` = 1; `out_valid` stays 0 for 10 cycles.
  - With the macro undefined: `out_pc` = 040 two edges later.
